// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constants, initial hash values,
// state/word types, FSM encoding and the FIPS 180-4 bit functions.
package sha256_pkg;

    typedef logic [31:0] word_t;
    // Element 7 is a/H0, element 0 is h/H7, so {a..h} maps MSB first.
    typedef word_t [7:0]  st8_t;
    // Element 15 is the oldest word W[t], element 0 the newest.
    typedef word_t [15:0] win_t;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, HOLD} state_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam st8_t IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam st8_t IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t e0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t e1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t s0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t s1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round plus one message-schedule step.
// Ports: i_st/o_st working vars a..h, i_win/o_win 16-word window, i_k constant.
module sha256_round
    import sha256_pkg::*;
(
    input  st8_t  i_st,
    input  win_t  i_win,
    input  word_t i_k,
    output st8_t  o_st,
    output win_t  o_win
);

    word_t w_t1;
    word_t w_t2;
    word_t w_new;

    // a=[7] b=[6] c=[5] d=[4] e=[3] f=[2] g=[1] h=[0]
    assign w_t1 = i_st[0] + e1(i_st[3]) + ch(i_st[3], i_st[2], i_st[1])
                + i_k + i_win[15];
    assign w_t2 = e0(i_st[7]) + maj(i_st[7], i_st[6], i_st[5]);

    assign o_st = {w_t1 + w_t2, i_st[7], i_st[6], i_st[5],
                   i_st[4] + w_t1, i_st[3], i_st[2], i_st[1]};

    // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]
    assign w_new = s1(i_win[1]) + i_win[6] + s0(i_win[14]) + i_win[15];
    assign o_win = {i_win[14:0], w_new};

endmodule

// File: rtl/sha256_core.sv
// SHA-256/224 block core, UNROLL rounds per clock, valid/ready in and out.
// Ports: clk, rst (sync high), in_* block handshake, out_* digest handshake, busy.
module sha256_core
    import sha256_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_first,
    input  logic         in_last,
    input  logic         in_mode224,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest,
    output logic         busy
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 &&
        UNROLL != 16 && UNROLL != 32 && UNROLL != 64) begin : g_bad_unroll
        $error("sha256_core: UNROLL must be 1,2,4,8,16,32 or 64");
    end

    state_t         r_state;
    logic   [6:0]   r_cnt;
    st8_t           r_work;
    win_t           r_win;
    st8_t           r_chain;
    logic           r_mode;
    logic           r_last;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_busy;
    logic   [255:0] r_digest;

    st8_t           w_st  [UNROLL+1];
    win_t           w_win [UNROLL+1];
    st8_t           w_sum;
    st8_t           w_iv;
    logic   [255:0] w_dig;
    logic   [6:0]   w_cnt_nxt;

    assign w_st[0]  = r_work;
    assign w_win[0] = r_win;

    for (genvar u = 0; u < UNROLL; u++) begin : g_rnd
        sha256_round u_rnd (
            .i_st  (w_st[u]),
            .i_win (w_win[u]),
            .i_k   (K[r_cnt[5:0] + 6'(u)]),
            .o_st  (w_st[u+1]),
            .o_win (w_win[u+1])
        );
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_sum[i] = r_chain[i] + r_work[i];
        end
    end

    assign w_iv      = in_mode224 ? IV224 : IV256;
    assign w_dig     = r_mode ? {w_sum[7:1], 32'h0} : w_sum;
    assign w_cnt_nxt = r_cnt + 7'(UNROLL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_win       <= '0;
            r_chain     <= '0;
            r_mode      <= 1'b0;
            r_last      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_digest    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_win      <= in_block;
                        r_cnt      <= '0;
                        r_last     <= in_last;
                        r_state    <= ROUND;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (in_first) begin
                            // New message: prior chain is discarded.
                            r_work  <= w_iv;
                            r_chain <= w_iv;
                            r_mode  <= in_mode224;
                        end else begin
                            r_work <= r_chain;
                        end
                    end
                end
                ROUND: begin
                    r_work <= w_st[UNROLL];
                    r_win  <= w_win[UNROLL];
                    r_cnt  <= w_cnt_nxt;
                    if (w_cnt_nxt == 7'd64) begin
                        r_state <= FINAL;
                    end
                end
                FINAL: begin
                    r_chain <= w_sum;
                    if (r_last) begin
                        r_digest    <= w_dig;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_digest = r_digest;
    assign busy       = r_busy;

endmodule

// File: tb/tb_sha256_core.sv
// Directed bench for sha256_core: three instances (UNROLL 1/4/64),
// known-answer digests, latency, hold, restart and reset-abort sequences.
module tb_sha256_core;

    localparam logic [511:0] B_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_2A = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_2B = {448'h0, 64'h1c0};
    localparam logic [255:0] D_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_2BLK =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] D_224 =
        {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] in_block;
    logic         in_first;
    logic         in_last;
    logic         in_mode224;
    logic         in_valid_v   [3];
    logic         in_ready_v   [3];
    logic         out_valid_v  [3];
    logic         out_ready_v  [3];
    logic         busy_v       [3];
    logic [255:0] out_digest_v [3];

    always #5 clk = ~clk;

    sha256_core #(.UNROLL(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_block(in_block), .in_first(in_first), .in_last(in_last),
        .in_mode224(in_mode224), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .out_digest(out_digest_v[0]), .busy(busy_v[0]));

    sha256_core #(.UNROLL(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_block(in_block), .in_first(in_first), .in_last(in_last),
        .in_mode224(in_mode224), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .out_digest(out_digest_v[1]), .busy(busy_v[1]));

    sha256_core #(.UNROLL(64)) u_c64 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_block(in_block), .in_first(in_first), .in_last(in_last),
        .in_mode224(in_mode224), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .out_digest(out_digest_v[2]), .busy(busy_v[2]));

    typedef struct {
        int           idx;
        logic [511:0] blk;
        logic         first;
        logic         last;
        logic         mode;
        logic [255:0] dig;
        int           lat;
        string        nm;
    } vec_t;

    vec_t tv[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic add(input int idx, input logic [511:0] blk, input logic first,
                       input logic last, input logic mode, input logic [255:0] dig,
                       input int lat, input string nm);
        vec_t v;
        v.idx = idx; v.blk = blk; v.first = first; v.last = last;
        v.mode = mode; v.dig = dig; v.lat = lat; v.nm = nm;
        tv.push_back(v);
    endtask

    // Called at a negedge. Latency counts rising edges from the accept edge.
    task automatic apply(input vec_t v);
        int           n;
        int           got_lat;
        logic         done;
        logic         seen;
        logic [255:0] got_dig;
        n = 0;
        while (!in_ready_v[v.idx] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({v.nm, " ready"}, 256'(in_ready_v[v.idx]), 256'd1);
        in_block   = v.blk;
        in_first   = v.first;
        in_last    = v.last;
        in_mode224 = v.mode;
        in_valid_v[v.idx] = 1'b1;
        n = 0; got_lat = -1; done = 1'b0; seen = 1'b0; got_dig = '0;
        while (!done && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            in_valid_v[v.idx] = 1'b0;
            if (v.last) begin
                if (out_valid_v[v.idx]) begin
                    got_lat = n;
                    got_dig = out_digest_v[v.idx];
                    done = 1'b1;
                end
            end else begin
                if (out_valid_v[v.idx]) seen = 1'b1;
                if (in_ready_v[v.idx]) begin
                    got_lat = n;
                    done = 1'b1;
                end
            end
        end
        chk({v.nm, " latency"}, 256'(got_lat), 256'(v.lat));
        if (v.last) chk({v.nm, " digest"}, got_dig, v.dig);
        else chk({v.nm, " no out_valid"}, 256'(seen), 256'd0);
    endtask

    initial begin
        int           bad;
        int           n;
        logic [255:0] held;
        logic         seen;
        vec_t         v;

        rst = 1'b1;
        in_block = '0; in_first = 1'b0; in_last = 1'b0; in_mode224 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_v[i] = 1'b0;
            out_ready_v[i] = 1'b1;
        end

        add(0, B_ABC,   1, 1, 0, D_ABC,   66, "u1 abc");
        add(0, B_EMPTY, 1, 1, 0, D_EMPTY, 66, "u1 empty");
        add(1, B_EMPTY, 1, 1, 0, D_EMPTY, 18, "u4 empty");
        add(2, B_EMPTY, 1, 1, 0, D_EMPTY, 3,  "u64 empty");
        add(0, B_ABC,   1, 1, 1, D_224,   66, "u1 abc224");
        add(0, B_2A,    1, 0, 0, '0,      66, "u1 2blk b1");
        add(0, B_2B,    0, 1, 0, D_2BLK,  66, "u1 2blk b2");
        add(1, B_2A,    1, 0, 0, '0,      18, "u4 2blk b1");
        add(1, B_2B,    0, 1, 0, D_2BLK,  18, "u4 2blk b2");
        add(2, B_ABC,   1, 1, 0, D_ABC,   3,  "u64 abc");
        add(0, B_2A,    1, 0, 0, '0,      66, "u1 restart b1");
        add(0, B_ABC,   1, 1, 0, D_ABC,   66, "u1 restart abc");
        add(2, B_ABC,   1, 1, 1, D_224,   3,  "u64 abc224");

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst in_ready %0d", i), 256'(in_ready_v[i]), 256'd1);
            chk($sformatf("rst out_valid %0d", i), 256'(out_valid_v[i]), 256'd0);
            chk($sformatf("rst busy %0d", i), 256'(busy_v[i]), 256'd0);
            chk($sformatf("rst digest %0d", i), out_digest_v[i], 256'd0);
        end

        foreach (tv[i]) apply(tv[i]);

        // Consumer stalls: digest must hold, inputs must be ignored.
        out_ready_v[0] = 1'b0;
        in_block = B_ABC; in_first = 1'b1; in_last = 1'b1; in_mode224 = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        chk("hold busy in round", 256'(busy_v[0]), 256'd1);
        n = 0;
        while (!out_valid_v[0] && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        held = out_digest_v[0];
        chk("hold digest", held, D_ABC);
        in_block = B_EMPTY;
        in_valid_v[0] = 1'b1;
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (out_digest_v[0] !== held || !out_valid_v[0] || in_ready_v[0]) bad++;
        end
        chk("hold stable", 256'(bad), 256'd0);
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold release in_ready", 256'(in_ready_v[0]), 256'd1);
        chk("hold release out_valid", 256'(out_valid_v[0]), 256'd0);
        @(posedge clk);
        @(negedge clk);
        chk("hold ignored input busy", 256'(busy_v[0]), 256'd0);

        // Reset mid-round aborts the block with no digest.
        in_block = B_ABC; in_first = 1'b1; in_last = 1'b1;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort in_ready", 256'(in_ready_v[0]), 256'd1);
        chk("abort busy", 256'(busy_v[0]), 256'd0);
        chk("abort digest", out_digest_v[0], 256'd0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid_v[0]) seen = 1'b1;
        end
        chk("abort no out_valid", 256'(seen), 256'd0);
        v.idx = 0; v.blk = B_EMPTY; v.first = 1'b1; v.last = 1'b1;
        v.mode = 1'b0; v.dig = D_EMPTY; v.lat = 66; v.nm = "u1 empty after abort";
        apply(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
